// File: rtl/dbp_bht_updater.sv
// Write-side BHT controller: buffers branch resolutions and applies each as a saturating-counter RMW on port 2.
// Optional statistics counters are enabled by defining DBP_UPD_STATS_EN.
module dbp_bht_updater #(
  parameter int unsigned AWIDTH     = 10,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic              upd_mispred,
  output logic [AWIDTH-1:0] bht_add,
  input  logic [DWIDTH-1:0] bht_rdata,
  output logic              bht_wen,
  output logic [DWIDTH-1:0] bht_wdata,
  output logic              busy
`ifdef DBP_UPD_STATS_EN
  ,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_FW = PTR_W + 1;

  typedef enum logic {IDLE, RMW} state_t;

  typedef struct packed {
    logic [AWIDTH-1:0] idx;
    logic              taken;
    logic              mispred;
  } upd_ent_t;

  state_t              state_q, state_d;
  upd_ent_t            fifo_q [FIFO_DEPTH];
  upd_ent_t            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]   count_q, count_d;

  logic                full, empty, push, pop;
  upd_ent_t            head, new_ent;
  logic [CNT_W-1:0]    cnt, cnt_new;

  assign full    = (count_q == CNT_FW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = fifo_q[rd_ptr_q];
  assign new_ent = '{idx: upd_pc[AWIDTH+1:2], taken: upd_taken, mispred: upd_mispred};

  assign upd_ready = !full && !reset;
  assign push      = upd_valid && upd_ready;
  assign busy      = (!empty || (state_q == RMW)) && !reset;
  assign cnt       = bht_rdata[CNT_W-1:0];

  // Saturating counter step towards the resolved outcome
  always_comb begin
    cnt_new = cnt;
    if (head.taken) begin
      if (cnt != {CNT_W{1'b1}}) cnt_new = cnt + CNT_W'(1);
    end else begin
      if (cnt != '0) cnt_new = cnt - CNT_W'(1);
    end
  end

  // FSM next state and port-2 drive; read is issued in IDLE, write lands in RMW
  always_comb begin
    state_d   = state_q;
    bht_add   = '0;
    bht_wen   = 1'b0;
    bht_wdata = '0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          bht_add = head.idx;
          state_d = RMW;
        end
      end
      RMW: begin
        bht_add                = head.idx;
        bht_wdata              = bht_rdata;
        bht_wdata[CNT_W-1:0]   = cnt_new;
        bht_wen                = 1'b1;
        pop                    = 1'b1;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      bht_add   = '0;
      bht_wen   = 1'b0;
      bht_wdata = '0;
      pop       = 1'b0;
    end
  end

  // Resolution FIFO bookkeeping
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = new_ent;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_FW'(push) - CNT_FW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef DBP_UPD_STATS_EN
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_updates_d = stat_updates_q;
    stat_mispred_d = stat_mispred_q;
    if (pop && (stat_updates_q != 32'hFFFF_FFFF)) stat_updates_d = stat_updates_q + 32'd1;
    if (pop && head.mispred && (stat_mispred_q != 32'hFFFF_FFFF))
      stat_mispred_d = stat_mispred_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_updates_q <= stat_updates_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[31:AWIDTH+2], upd_pc[1:0]};
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[31:AWIDTH+2], upd_pc[1:0], head.mispred};
`endif

endmodule

// File: tb/tb_dbp_bht_updater.sv
// Scoreboard bench for dbp_bht_updater with a behavioural BHT port-2 model.
// Define DBP_UPD_STATS_EN to also check the statistics counters.
module tb_dbp_bht_updater;
  localparam int unsigned AWIDTH = 10;
  localparam int unsigned DWIDTH = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              upd_valid = 1'b0;
  logic              upd_taken = 1'b0;
  logic              upd_mispred = 1'b0;
  logic [31:0]       upd_pc = '0;
  logic              upd_ready, bht_wen, busy;
  logic [AWIDTH-1:0] bht_add;
  logic [DWIDTH-1:0] bht_rdata, bht_wdata;
`ifdef DBP_UPD_STATS_EN
  logic [31:0]       stat_updates, stat_mispred;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int occ = 0;
  bit saw_full = 1'b0;

  typedef struct {
    logic [AWIDTH-1:0] idx;
    logic [DWIDTH-1:0] wdata;
  } exp_t;
  exp_t exp_q[$];

  logic [DWIDTH-1:0] mem [1<<AWIDTH];
  logic              pl_en = 1'b0;
  logic [AWIDTH-1:0] pl_idx = '0;
  logic [DWIDTH-1:0] pl_val = '0;

  always #5 clk = ~clk;

  dbp_bht_updater #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CNT_W(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .bht_add(bht_add), .bht_rdata(bht_rdata), .bht_wen(bht_wen), .bht_wdata(bht_wdata),
    .busy(busy)
`ifdef DBP_UPD_STATS_EN
    , .stat_updates(stat_updates), .stat_mispred(stat_mispred)
`endif
  );

  // Registered-read BHT port with bench-side preload
  always @(posedge clk) begin
    bht_rdata <= mem[bht_add];
    if (bht_wen) mem[bht_add] <= bht_wdata;
    if (pl_en) mem[pl_idx] <= pl_val;
  end

  // Expected FIFO occupancy
  always @(posedge clk) begin
    if (reset) occ <= 0;
    else occ <= occ + ((upd_valid && upd_ready) ? 1 : 0) - (bht_wen ? 1 : 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshake/busy checks every cycle, scoreboard pop on every write
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rst_ready", 64'(upd_ready), 64'd0);
      check("rst_wen", 64'(bht_wen), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_add", 64'(bht_add), 64'd0);
      check("rst_wdata", 64'(bht_wdata), 64'd0);
    end else begin
      check("ready", 64'(upd_ready), 64'(occ != DEPTH));
      check("busy", 64'(busy), 64'(occ != 0));
      if (!upd_ready) saw_full = 1'b1;
      if (bht_wen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(bht_add), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_idx", 64'(bht_add), 64'(e.idx));
          check("wr_data", 64'(bht_wdata), 64'(e.wdata));
        end
      end
    end
  end

  task automatic preload(input logic [AWIDTH-1:0] idx, input logic [DWIDTH-1:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic mp,
                      input logic [AWIDTH-1:0] eidx, input logic [DWIDTH-1:0] ewd,
                      input bit expect_write);
    bit acc;
    int k;
    exp_t e;
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_mispred = mp;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 100) begin
      @(negedge clk);
      acc = upd_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!acc) check("push_timeout", 64'd0, 64'd1);
    else if (expect_write) begin
      e.idx = eidx; e.wdata = ewd;
      exp_q.push_back(e);
    end
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [DWIDTH-1:0] v_init [8] = '{32'h0, 32'h3, 32'hFFFF_FFFF, 32'h1234_5672,
                                    32'h10, 32'h2, 32'h1, 32'h8000_0002};
  logic              v_tk   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic              v_mp   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [DWIDTH-1:0] v_exp  [8] = '{32'h1, 32'h2, 32'hFFFF_FFFF, 32'h1234_5671,
                                    32'h10, 32'h3, 32'h0, 32'h8000_0003};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    preload(10'd0, 32'h0);
    preload(10'd5, 32'h1);
    preload(10'd7, 32'hABCD_0003);
    preload(10'd2, 32'h0);
    preload(10'd9, 32'h55);
    for (int i = 0; i < 8; i++) preload(AWIDTH'(16 + i), v_init[i]);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(upd_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
`ifdef DBP_UPD_STATS_EN
    check("post_rst_stat_upd", 64'(stat_updates), 64'd0);
    check("post_rst_stat_mp", 64'(stat_mispred), 64'd0);
`endif
    @(posedge clk); #1;

    // Increment with exact read/write latency
    push(32'h14, 1'b1, 1'b0, 10'd5, 32'h2, 1'b1);
    @(negedge clk);
    check("lat_read_add", 64'(bht_add), 64'd5);
    check("lat_read_wen", 64'(bht_wen), 64'd0);
    @(negedge clk);
    check("lat_write_wen", 64'(bht_wen), 64'd1);
    check("lat_write_add", 64'(bht_add), 64'd5);
    check("lat_write_data", 64'(bht_wdata), 64'h2);
    wait_idle();

    push(32'h1C, 1'b1, 1'b1, 10'd7, 32'hABCD_0003, 1'b1);
    wait_idle();
    push(32'h08, 1'b0, 1'b0, 10'd2, 32'h0, 1'b1);
    wait_idle();

    // Back-pressure burst
    for (int i = 0; i < 8; i++)
      push(32'h40 + 32'(4 * i), v_tk[i], v_mp[i], AWIDTH'(16 + i), v_exp[i], 1'b1);
    wait_idle();
    check("saw_full", 64'(saw_full), 64'd1);
    check("burst_drained", 64'(exp_q.size()), 64'd0);

    // Same index back to back: second read must see the first write
    preload(10'd5, 32'h1);
    push(32'h14, 1'b1, 1'b0, 10'd5, 32'h2, 1'b1);
    push(32'h14, 1'b1, 1'b0, 10'd5, 32'h3, 1'b1);
    wait_idle();
    check("b2b_mem", 64'(mem[5]), 64'h3);
`ifdef DBP_UPD_STATS_EN
    check("stat_upd_13", 64'(stat_updates), 64'd13);
    check("stat_mp_3", 64'(stat_mispred), 64'd3);
`endif

    // Reset during RMW aborts the write
    push(32'h24, 1'b1, 1'b1, 10'd9, 32'h56, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_wen", 64'(bht_wen), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(upd_ready), 64'd1);
    check("abort_mem", 64'(mem[9]), 64'h55);
    check("abort_q", 64'(exp_q.size()), 64'd0);
`ifdef DBP_UPD_STATS_EN
    check("abort_stat_upd", 64'(stat_updates), 64'd0);
    check("abort_stat_mp", 64'(stat_mispred), 64'd0);
`endif
    @(posedge clk); #1;

    push(32'h24, 1'b1, 1'b0, 10'd9, 32'h56, 1'b1);
    push(32'h24, 1'b1, 1'b1, 10'd9, 32'h57, 1'b1);
    push(32'h24, 1'b0, 1'b0, 10'd9, 32'h56, 1'b1);
    wait_idle();
    check("final_mem", 64'(mem[9]), 64'h56);
`ifdef DBP_UPD_STATS_EN
    check("stat_upd_3", 64'(stat_updates), 64'd3);
    check("stat_mp_1", 64'(stat_mispred), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("stat_upd_rst", 64'(stat_updates), 64'd0);
    check("stat_mp_rst", 64'(stat_mispred), 64'd0);
`endif
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
